// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB FSM sharing one ALU,
// with internal instruction/data memories and a 32x32 register file.

module mips_mc_imem #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic [AW-1:0] idx,
    output logic [31:0]   data
);
    logic [31:0] memory [DEPTH];

    assign data = memory[idx];
endmodule

module mips_mc_dmem #(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] memory [DEPTH];

    always_ff @(posedge clk) begin
        if (we) memory[idx] <= wdata;
    end

    assign rdata = memory[idx];
endmodule

module mips_mc_rf (
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr_a,
    input  logic [4:0]  raddr_b,
    input  logic [4:0]  raddr_dbg,
    output logic [31:0] rdata_a,
    output logic [31:0] rdata_b,
    output logic [31:0] rdata_dbg
);
    logic [31:0] registers [32];

    always_ff @(posedge clk) begin
        if (we && waddr != 5'd0) registers[waddr] <= wdata;
    end

    assign rdata_a   = (raddr_a   == 5'd0) ? '0 : registers[raddr_a];
    assign rdata_b   = (raddr_b   == 5'd0) ? '0 : registers[raddr_b];
    assign rdata_dbg = (raddr_dbg == 5'd0) ? '0 : registers[raddr_dbg];
endmodule

module mips_multicycle_core #(
    parameter int unsigned IMEM_DEPTH = 1024,
    parameter int unsigned DMEM_DEPTH = 4096,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run_en,
    input  logic [4:0]  dbg_reg_addr,
    output logic [31:0] dbg_reg_data,
    output logic [31:0] pc,
    output logic [2:0]  state,
    output logic        halted,
    output logic [31:0] retired_cnt
);
    localparam int unsigned IAW = $clog2(IMEM_DEPTH);
    localparam int unsigned DAW = $clog2(DMEM_DEPTH);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_fn_t;

    state_t      cur_state, next_state;
    alu_fn_t     alu_fn;
    logic [31:0] pc_q, ir, a_q, b_q, alu_out, mdr, retired_q;
    logic [31:0] alu_x, alu_y, alu_res, pc_next, imm;
    logic [31:0] imem_data, dmem_rdata, rf_a, rf_b, rf_wdata;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, rf_waddr;
    logic        alu_zero, needs_exec;
    logic        ir_we, pc_we, ab_we, alu_we, mdr_we, dmem_we, rf_we, retire;

    assign op    = ir[31:26];
    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign funct = ir[5:0];
    assign imm   = {{16{ir[15]}}, ir[15:0]};

    assign needs_exec = (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW) ||
                        (op == OP_SW) || (op == OP_BEQ);

    mips_mc_imem #(.DEPTH(IMEM_DEPTH)) imem (
        .idx  (pc_q[IAW+1:2]),
        .data (imem_data)
    );

    mips_mc_dmem #(.DEPTH(DMEM_DEPTH)) dmem (
        .clk   (clk),
        .we    (dmem_we),
        .idx   (alu_out[DAW+1:2]),
        .wdata (b_q),
        .rdata (dmem_rdata)
    );

    mips_mc_rf rf (
        .clk       (clk),
        .we        (rf_we),
        .waddr     (rf_waddr),
        .wdata     (rf_wdata),
        .raddr_a   (rs),
        .raddr_b   (rt),
        .raddr_dbg (dbg_reg_addr),
        .rdata_a   (rf_a),
        .rdata_b   (rf_b),
        .rdata_dbg (dbg_reg_data)
    );

    // Shared ALU: pc+4 in FETCH, branch target in DECODE, the operation itself in EXEC
    always_comb begin
        alu_x  = pc_q;
        alu_y  = 32'd4;
        alu_fn = ALU_ADD;
        case (cur_state)
            S_DECODE: alu_y = imm << 2;
            S_EXEC: begin
                alu_x = a_q;
                if (op == OP_RTYPE) begin
                    alu_y = b_q;
                    case (funct)
                        6'h22:   alu_fn = ALU_SUB;
                        6'h24:   alu_fn = ALU_AND;
                        6'h25:   alu_fn = ALU_OR;
                        6'h2A:   alu_fn = ALU_SLT;
                        default: alu_fn = ALU_ADD;
                    endcase
                end else if (op == OP_BEQ) begin
                    alu_y  = b_q;
                    alu_fn = ALU_SUB;
                end else begin
                    alu_y = imm;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        case (alu_fn)
            ALU_SUB: alu_res = alu_x - alu_y;
            ALU_AND: alu_res = alu_x & alu_y;
            ALU_OR:  alu_res = alu_x | alu_y;
            ALU_SLT: alu_res = ($signed(alu_x) < $signed(alu_y)) ? 32'd1 : 32'd0;
            default: alu_res = alu_x + alu_y;
        endcase
    end

    assign alu_zero = (alu_res == 32'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur_state <= S_FETCH;
        else        cur_state <= next_state;
    end

    always_comb begin
        next_state = cur_state;
        if (run_en) begin
            case (cur_state)
                S_FETCH:  next_state = S_DECODE;
                S_DECODE: begin
                    if (op == OP_HALT)  next_state = S_HALT;
                    else if (needs_exec) next_state = S_EXEC;
                    else                 next_state = S_FETCH;
                end
                S_EXEC: begin
                    if (op == OP_LW || op == OP_SW) next_state = S_MEM;
                    else if (op == OP_BEQ)          next_state = S_FETCH;
                    else                            next_state = S_WB;
                end
                S_MEM:   next_state = (op == OP_LW) ? S_WB : S_FETCH;
                S_WB:    next_state = S_FETCH;
                default: next_state = cur_state;
            endcase
        end
    end

    // All enables are gated by run_en so a stall freezes every register and memory
    always_comb begin
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        ab_we   = 1'b0;
        alu_we  = 1'b0;
        mdr_we  = 1'b0;
        dmem_we = 1'b0;
        rf_we   = 1'b0;
        retire  = 1'b0;
        pc_next = alu_res;
        if (run_en) begin
            case (cur_state)
                S_FETCH: begin
                    ir_we = 1'b1;
                    pc_we = 1'b1;
                end
                S_DECODE: begin
                    ab_we  = 1'b1;
                    alu_we = 1'b1;
                    retire = !needs_exec;
                    if (op == OP_J) begin
                        pc_we   = 1'b1;
                        pc_next = {pc_q[31:28], ir[25:0], 2'b00};
                    end
                end
                S_EXEC: begin
                    if (op == OP_BEQ) begin
                        retire  = 1'b1;
                        pc_we   = alu_zero;
                        pc_next = alu_out;
                    end else begin
                        alu_we = 1'b1;
                    end
                end
                S_MEM: begin
                    if (op == OP_LW) begin
                        mdr_we = 1'b1;
                    end else begin
                        dmem_we = 1'b1;
                        retire  = 1'b1;
                    end
                end
                S_WB: begin
                    rf_we  = 1'b1;
                    retire = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign rf_waddr = (op == OP_RTYPE) ? rd : rt;
    assign rf_wdata = (op == OP_LW) ? mdr : alu_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            ir        <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out   <= '0;
            mdr       <= '0;
            retired_q <= '0;
        end else begin
            if (ir_we)  ir      <= imem_data;
            if (pc_we)  pc_q    <= pc_next;
            if (ab_we) begin
                a_q <= rf_a;
                b_q <= rf_b;
            end
            if (alu_we) alu_out <= alu_res;
            if (mdr_we) mdr     <= dmem_rdata;
            if (retire) retired_q <= retired_q + 32'd1;
        end
    end

    assign pc          = pc_q;
    assign state       = cur_state;
    assign halted      = (cur_state == S_HALT);
    assign retired_cnt = retired_q;
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core: instruction-level reference model checked every
// cycle, directed programs with literal expectations, then random programs.

module tb_mips_multicycle_core;
    localparam int unsigned IMEM_DEPTH = 1024;
    localparam int unsigned DMEM_DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run_en = 1'b0;
    logic [4:0]  dbg_reg_addr = 5'd0;
    logic [31:0] dbg_reg_data, pc, retired_cnt;
    logic [2:0]  state;
    logic        halted;

    always #5 clk = ~clk;

    mips_multicycle_core #(
        .IMEM_DEPTH (IMEM_DEPTH),
        .DMEM_DEPTH (DMEM_DEPTH),
        .RESET_PC   (32'h0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run_en       (run_en),
        .dbg_reg_addr (dbg_reg_addr),
        .dbg_reg_data (dbg_reg_data),
        .pc           (pc),
        .state        (state),
        .halted       (halted),
        .retired_cnt  (retired_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (one instruction at a time) ----------------
    logic [31:0] mim [IMEM_DEPTH];
    logic [31:0] mdm [DMEM_DEPTH];
    logic [31:0] mrf [32];
    logic [31:0] m_pc = 32'h0, m_ret = 32'h0, m_ir = 32'h0;
    int unsigned m_phase = 0;
    bit          m_halt = 1'b0;
    bit          cmp_en = 1'b0;

    function automatic int unsigned widx(input logic [31:0] addr, input int unsigned depth);
        return (addr >> 2) & (depth - 1);
    endfunction

    // cycles an instruction occupies from its fetch to its completing edge
    function automatic int unsigned latency(input logic [31:0] w);
        case (w[31:26])
            6'h00, 6'h08, 6'h2B: return 4;
            6'h23:               return 5;
            6'h04:               return 3;
            default:             return 2;
        endcase
    endfunction

    function automatic logic [2:0] exp_state();
        if (m_halt) return 3'd5;
        case (m_phase)
            0: return 3'd0;
            1: return 3'd1;
            2: return 3'd2;
            3: return (m_ir[31:26] == 6'h23 || m_ir[31:26] == 6'h2B) ? 3'd3 : 3'd4;
            default: return 3'd4;
        endcase
    endfunction

    task automatic model_complete();
        logic [31:0] a, b, imm, res, ea;
        logic [4:0]  rs, rt, rd;
        rs  = m_ir[25:21];
        rt  = m_ir[20:16];
        rd  = m_ir[15:11];
        a   = mrf[rs];
        b   = mrf[rt];
        imm = {{16{m_ir[15]}}, m_ir[15:0]};
        ea  = a + imm;
        case (m_ir[31:26])
            6'h00: begin
                case (m_ir[5:0])
                    6'h22:   res = a - b;
                    6'h24:   res = a & b;
                    6'h25:   res = a | b;
                    6'h2A:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: res = a + b;
                endcase
                if (rd != 5'd0) mrf[rd] = res;
            end
            6'h08: if (rt != 5'd0) mrf[rt] = ea;
            6'h23: if (rt != 5'd0) mrf[rt] = mdm[widx(ea, DMEM_DEPTH)];
            6'h2B: mdm[widx(ea, DMEM_DEPTH)] = b;
            6'h04: if (a == b) m_pc = m_pc + (imm << 2);
            6'h02: m_pc = {m_pc[31:28], m_ir[25:0], 2'b00};
            6'h3F: m_halt = 1'b1;
            default: ;
        endcase
        m_ret = m_ret + 32'd1;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_pc = 32'h0; m_ret = 32'h0; m_ir = 32'h0; m_phase = 0; m_halt = 1'b0;
        end else if (!m_halt && run_en) begin
            if (m_phase == 0) begin
                m_ir = mim[widx(m_pc, IMEM_DEPTH)];
                m_pc = m_pc + 32'd4;
            end
            m_phase++;
            if (m_phase == latency(m_ir)) begin
                model_complete();
                m_phase = 0;
            end
        end
    end

    // per-cycle compare against the model
    initial forever begin
        @(negedge clk);
        dbg_reg_addr = 5'($urandom_range(0, 31));
        #1;
        if (cmp_en) begin
            check("state",       32'(state),  32'(exp_state()));
            check("pc",          pc,          m_pc);
            check("halted",      32'(halted), 32'(m_halt));
            check("retired_cnt", retired_cnt, m_ret);
            check("dbg_reg_data", dbg_reg_data, mrf[dbg_reg_addr]);
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction
    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction
    function automatic logic [31:0] enc_j(input logic [25:0] t);
        return {6'h02, t};
    endfunction

    task automatic put_instr(input logic [31:0] addr, input logic [31:0] w);
        dut.imem.memory[widx(addr, IMEM_DEPTH)] = w;
        mim[widx(addr, IMEM_DEPTH)] = w;
    endtask
    task automatic set_reg(input int unsigned r, input logic [31:0] v);
        dut.rf.registers[r] = v;
        mrf[r] = v;
    endtask
    task automatic set_dmem(input int unsigned i, input logic [31:0] v);
        dut.dmem.memory[i] = v;
        mdm[i] = v;
    endtask
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] rand_instr();
        int unsigned r = $urandom_range(0, 99);
        logic [4:0]  rs = 5'($urandom_range(0, 7));
        logic [4:0]  rt = 5'($urandom_range(0, 7));
        logic [4:0]  rd = 5'($urandom_range(0, 7));
        logic [5:0]  fn;
        case ($urandom_range(0, 5))
            0: fn = 6'h20;
            1: fn = 6'h22;
            2: fn = 6'h24;
            3: fn = 6'h25;
            4: fn = 6'h2A;
            default: fn = 6'($urandom);
        endcase
        if (r < 30) return enc_r(rs, rt, rd, fn);
        if (r < 45) return enc_i(6'h08, rs, rt, 16'($urandom));
        if (r < 55) return enc_i(6'h23, rs, rt, 16'($urandom));
        if (r < 65) return enc_i(6'h2B, rs, rt, 16'($urandom));
        if (r < 75) return enc_i(6'h04, rs, rt, 16'($urandom_range(0, 8)) - 16'd4);
        if (r < 80) return enc_j(26'($urandom_range(0, IMEM_DEPTH - 1)));
        if (r < 84) return 32'hFC000000;
        if (r < 88) begin
            case ($urandom_range(0, 3))
                0: return enc_i(6'h01, rs, rt, 16'($urandom));
                1: return enc_i(6'h05, rs, rt, 16'($urandom));
                2: return enc_i(6'h0A, rs, rt, 16'($urandom));
                default: return enc_i(6'h3E, rs, rt, 16'($urandom));
            endcase
        end
        return enc_r(rs, rt, rd, 6'h20);
    endfunction

    task automatic preload_random();
        for (int i = 0; i < int'(IMEM_DEPTH); i++) put_instr(32'(i) << 2, rand_instr());
        for (int i = 0; i < int'(DMEM_DEPTH); i++) set_dmem(i, $urandom);
        set_reg(0, 32'h0);
        for (int r = 1; r < 32; r++)
            set_reg(r, ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int budget;
        int bad;
        rst_n  = 1'b0;
        run_en = 1'b1;
        cycles(2);
        preload_random();
        for (int i = 0; i < int'(IMEM_DEPTH); i++) put_instr(32'(i) << 2, 32'h0);
        cmp_en = 1'b1;
        check("reset_pc",      pc,          32'h0);
        check("reset_state",   32'(state),  32'd0);
        check("reset_halted",  32'(halted), 32'd0);
        check("reset_retired", retired_cnt, 32'd0);

        // Program A: add, sw, lw, j, addi, slt, add to R0, halt
        set_reg(8, 32'd8);
        set_reg(9, 32'd9);
        set_dmem(1, 32'h0);
        put_instr(32'h00, enc_r(5'd8, 5'd9, 5'd12, 6'h20));
        put_instr(32'h04, enc_i(6'h2B, 5'd0, 5'd12, 16'd4));
        put_instr(32'h08, enc_i(6'h23, 5'd0, 5'd15, 16'd4));
        put_instr(32'h0C, enc_j(26'd10));
        put_instr(32'h28, enc_i(6'h08, 5'd0, 5'd3, 16'hFFFF));
        put_instr(32'h2C, enc_r(5'd3, 5'd0, 5'd4, 6'h2A));
        put_instr(32'h30, enc_r(5'd8, 5'd9, 5'd0, 6'h20));
        put_instr(32'h34, 32'hFC000000);
        rst_n = 1'b1;
        cycles(4);
        check("add_r12",     dut.rf.registers[12], 32'd17);
        check("add_retired", retired_cnt, 32'd1);
        check("add_pc",      pc, 32'h4);
        cycles(4);
        check("sw_dmem1",    dut.dmem.memory[1], 32'd17);
        cycles(5);
        check("lw_r15",      dut.rf.registers[15], 32'd17);
        check("lw_retired",  retired_cnt, 32'd3);
        cycles(2);
        check("j_pc",        pc, 32'h28);
        cycles(4);
        check("addi_r3",     dut.rf.registers[3], 32'hFFFFFFFF);
        cycles(4);
        check("slt_r4",      dut.rf.registers[4], 32'd1);
        cycles(4);
        check("r0_zero",     dut.rf.registers[0], 32'd0);
        cycles(2);
        check("haltA_halted", 32'(halted), 32'd1);
        check("haltA_pc",     pc, 32'h38);
        check("haltA_retired", retired_cnt, 32'd8);

        // Program B: branches, stalled sw, halt, reset mid-MEM
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        set_dmem(2, 32'h0000DEAD);
        set_dmem(3, 32'h0000BEEF);
        put_instr(32'h00, enc_i(6'h08, 5'd0, 5'd1, 16'd5));
        put_instr(32'h04, enc_i(6'h08, 5'd0, 5'd2, 16'd6));
        put_instr(32'h08, enc_i(6'h08, 5'd0, 5'd5, 16'd0));
        put_instr(32'h0C, enc_i(6'h08, 5'd0, 5'd6, 16'd0));
        put_instr(32'h10, enc_i(6'h04, 5'd1, 5'd1, 16'd2));
        put_instr(32'h14, 32'hFC000000);
        put_instr(32'h18, 32'hFC000000);
        put_instr(32'h1C, enc_i(6'h04, 5'd1, 5'd2, 16'd2));
        put_instr(32'h20, enc_i(6'h2B, 5'd0, 5'd1, 16'd8));
        put_instr(32'h24, 32'hFC000000);
        rst_n = 1'b1;
        cycles(16);
        check("pre_beq_pc", pc, 32'h10);
        cycles(3);
        check("beq_taken_pc", pc, 32'h1C);
        cycles(3);
        check("beq_not_taken_pc", pc, 32'h20);
        check("beq_retired", retired_cnt, 32'd6);
        cycles(3);
        check("sw_in_mem", 32'(state), 32'd3);
        run_en = 1'b0;
        cycles(5);
        check("stall_state", 32'(state), 32'd3);
        check("stall_pc",    pc, 32'h24);
        check("stall_dmem2", dut.dmem.memory[2], 32'h0000DEAD);
        run_en = 1'b1;
        cycles(1);
        check("stall_sw_lands", dut.dmem.memory[2], 32'd5);
        check("stall_retired",  retired_cnt, 32'd7);
        cycles(2);
        check("haltB_halted", 32'(halted), 32'd1);
        for (int i = 0; i < 20; i++) begin
            run_en = $urandom_range(0, 1) == 1;
            @(negedge clk);
        end
        check("haltB_pc",      pc, 32'h28);
        check("haltB_retired", retired_cnt, 32'd8);
        check("haltB_state",   32'(state), 32'd5);
        run_en = 1'b1;
        rst_n  = 1'b0;
        @(negedge clk);
        put_instr(32'h00, enc_i(6'h2B, 5'd0, 5'd1, 16'd12));
        rst_n = 1'b1;
        cycles(3);
        check("sw2_in_mem", 32'(state), 32'd3);
        rst_n = 1'b0;
        #1;
        check("midmem_reset_state", 32'(state), 32'd0);
        check("midmem_reset_pc",    pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(1);
        check("midmem_no_write", dut.dmem.memory[3], 32'h0000BEEF);

        // Random programs with random run_en stalls
        for (int p = 0; p < 6; p++) begin
            rst_n = 1'b0;
            @(negedge clk);
            preload_random();
            rst_n = 1'b1;
            budget = 800;
            while (!halted && budget > 0) begin
                run_en = $urandom_range(0, 9) != 0;
                @(negedge clk);
                budget--;
            end
            run_en = 1'b1;
            #2;
            bad = 0;
            for (int r = 0; r < 32; r++) begin
                if (dut.rf.registers[r] !== mrf[r]) begin
                    if (bad == 0) $display("FAIL rf_sweep r%0d: got %h expected %h", r, dut.rf.registers[r], mrf[r]);
                    bad++;
                end
            end
            check("rf_sweep_bad_count", 32'(bad), 32'd0);
            bad = 0;
            for (int i = 0; i < int'(DMEM_DEPTH); i++) begin
                if (dut.dmem.memory[i] !== mdm[i]) begin
                    if (bad == 0) $display("FAIL dmem_sweep [%0d]: got %h expected %h", i, dut.dmem.memory[i], mdm[i]);
                    bad++;
                end
            end
            check("dmem_sweep_bad_count", 32'(bad), 32'd0);
        end

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
